// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver, transmitter and register file.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  // Line control register layout, MSB first (dlab is LCR[7]).
  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  // Parity bit the line should carry, given the XOR of the data bits.
  function automatic logic parity_expect(input logic data_xor, input logic eps,
                                         input logic stick);
    if (stick) return ~eps;
    return eps ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer with a parameterized reset value; also used for modem status lines.
module sync_ff #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk) begin
    if (!reset) stg <= {STAGES{RST_VAL}};
    else        stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled serial receiver with parity, framing and break detection.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  rxd,
  input  logic                  rx_enable,
  input  logic [1:0]            wls,
  input  logic                  pen,
  input  logic                  eps,
  input  logic                  stick,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  break_int,
  output logic                  rx_active
);

  logic rxd_s;

  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  rx_state_t             state_q, state_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [1:0]            wls_q, wls_d;
  logic                  pen_q, pen_d, eps_q, eps_d, stick_q, stick_d;
  logic                  pbit_q, pbit_d, perr_q, perr_d;
  logic                  load_out, fe_d, brk_d;
  logic                  last_bit, tick_wrap;

  // Last data bit index is N-1 = 4 + wls.
  assign last_bit  = (bcnt_q == {1'b1, wls_q});
  assign tick_wrap = (tcnt_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    wls_d    = wls_q;
    pen_d    = pen_q;
    eps_d    = eps_q;
    stick_d  = stick_q;
    pbit_d   = pbit_q;
    perr_d   = perr_q;
    load_out = 1'b0;
    fe_d     = 1'b0;
    brk_d    = 1'b0;

    if (!rx_enable) begin
      state_d = IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
    end else if (sample_tick) begin
      case (state_q)
        IDLE: if (!rxd_s) begin
          state_d = START;
          tcnt_d  = '0;
          bcnt_d  = '0;
          shreg_d = '0;
          pbit_d  = 1'b0;
          perr_d  = 1'b0;
          wls_d   = wls;
          pen_d   = pen;
          eps_d   = eps;
          stick_d = stick;
        end
        START: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'(MID_SAMPLE - 1)) begin
            state_d = rxd_s ? IDLE : DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tick_wrap) begin
            shreg_d[bcnt_q] = rxd_s;
            bcnt_d          = bcnt_q + 3'd1;
            if (last_bit) begin
              state_d = pen_q ? PARITY : STOP;
              bcnt_d  = '0;
            end
          end
        end
        PARITY: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tick_wrap) begin
            pbit_d  = rxd_s;
            perr_d  = rxd_s != parity_expect(^shreg_q, eps_q, stick_q);
            state_d = STOP;
          end
        end
        STOP: begin
          tcnt_d = tcnt_q + 4'd1;
          if (tick_wrap) begin
            load_out = 1'b1;
            fe_d     = ~rxd_s;
            brk_d    = ~rxd_s & ~(|shreg_q) & ~(pen_q & pbit_q);
            // A held break parks in BRK_WAIT; a plain framing error resyncs from IDLE.
            state_d  = brk_d ? BRK_WAIT : IDLE;
            tcnt_d   = '0;
          end
        end
        BRK_WAIT: if (rxd_s) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      wls_q       <= '0;
      pen_q       <= 1'b0;
      eps_q       <= 1'b0;
      stick_q     <= 1'b0;
      pbit_q      <= 1'b0;
      perr_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_int   <= 1'b0;
      rx_active   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      wls_q     <= wls_d;
      pen_q     <= pen_d;
      eps_q     <= eps_d;
      stick_q   <= stick_d;
      pbit_q    <= pbit_d;
      perr_q    <= perr_d;
      rx_valid  <= load_out;
      rx_active <= (state_d != IDLE);
      if (load_out) begin
        rx_data     <= shreg_q;
        parity_err  <= perr_q;
        framing_err <= fe_d;
        break_int   <= brk_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a tick every 4 clk and a bit-level serializer.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick;
  logic       rxd = 1'b1;
  logic       rx_enable = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       pen = 1'b0, eps = 1'b0, stick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, break_int, rx_active;

  int checks = 0, failures = 0;
  int cyc = 0, vld_cnt = 0, vld_cyc = 0, act_cyc = 0;
  logic act_prev = 1'b0, act_seen = 1'b0;
  logic [1:0] tdiv = '0;

  uart_rx_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rxd(rxd),
    .rx_enable(rx_enable), .wls(wls), .pen(pen), .eps(eps), .stick(stick),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .framing_err(framing_err), .break_int(break_int), .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  // DL=4, PSD=0: one tick every fourth clk.
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign sample_tick = (tdiv == 2'd3);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      vld_cnt <= vld_cnt + 1;
      vld_cyc <= cyc;
    end
    if (rx_active && !act_prev) begin
      act_cyc  <= cyc;
      act_seen <= 1'b1;
    end
    act_prev <= rx_active;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lcr(input logic [1:0] w, input logic p, input logic e, input logic s);
    wls = w; pen = p; eps = e; stick = s;
  endtask

  // One frame; stop_lo>0 drives the stop bit low for that many clk, then the line goes high.
  task automatic send(input logic [7:0] d, input int n, input logic use_p,
                      input logic pbit, input int stop_lo);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      repeat (64) @(negedge clk);
    end
    if (use_p) begin
      rxd = pbit;
      repeat (64) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (stop_lo) @(negedge clk);
    rxd = 1'b1;
    repeat (192) @(negedge clk);
  endtask

  task automatic expect_char(input string tg, input int cnt0, input logic [7:0] d,
                             input logic pe, input logic fe, input logic bk);
    chk({tg, "_cnt"}, vld_cnt - cnt0, 1);
    chk({tg, "_data"}, rx_data, d);
    chk({tg, "_perr"}, parity_err, pe);
    chk({tg, "_ferr"}, framing_err, fe);
    chk({tg, "_brk"}, break_int, bk);
    chk({tg, "_act"}, rx_active, 1'b0);
  endtask

  initial begin
    int c0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_vld", rx_valid, 1'b0);
    chk("rst_act", rx_active, 1'b0);
    chk("rst_flags", {parity_err, framing_err, break_int}, 3'b000);
    repeat (20) @(negedge clk);

    // 8N1 0x55 with latency check
    set_lcr(2'b11, 0, 0, 0);
    c0 = vld_cnt;
    send(8'h55, 8, 0, 0, 0);
    expect_char("n8_55", c0, 8'h55, 0, 0, 0);
    chk("n8_lat", vld_cyc - act_cyc, 608);

    // 5E1 0x15: three ones, even parity bit 1
    set_lcr(2'b00, 1, 1, 0);
    c0 = vld_cnt;
    send(8'h15, 5, 1, 1'b1, 0);
    expect_char("e5_ok", c0, 8'h15, 0, 0, 0);
    c0 = vld_cnt;
    send(8'h15, 5, 1, 1'b0, 0);
    expect_char("e5_bad", c0, 8'h15, 1, 0, 0);

    // 7O1 0x7F: seven ones, odd parity bit 0
    set_lcr(2'b10, 1, 0, 0);
    c0 = vld_cnt;
    send(8'h7F, 7, 1, 1'b0, 0);
    expect_char("o7_7f", c0, 8'h7F, 0, 0, 0);

    // stick parity, eps=1 -> bit must be 0
    set_lcr(2'b11, 1, 1, 1);
    c0 = vld_cnt;
    send(8'h01, 8, 1, 1'b0, 0);
    expect_char("stk_ok", c0, 8'h01, 0, 0, 0);
    c0 = vld_cnt;
    send(8'h01, 8, 1, 1'b1, 0);
    expect_char("stk_bad", c0, 8'h01, 1, 0, 0);

    // glitch: 4-tick low pulse
    set_lcr(2'b11, 0, 0, 0);
    c0 = vld_cnt;
    act_seen = 1'b0;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("gl_seen", act_seen, 1'b1);
    chk("gl_act", rx_active, 1'b0);
    chk("gl_cnt", vld_cnt - c0, 0);

    // framing error: stop bit low long enough to be sampled, then high
    c0 = vld_cnt;
    send(8'hA3, 8, 0, 0, 40);
    expect_char("fe_a3", c0, 8'hA3, 0, 1, 0);

    // break: 40 bit times low
    c0 = vld_cnt;
    rxd = 1'b0;
    repeat (64 * 40) @(negedge clk);
    chk("brk_cnt", vld_cnt - c0, 1);
    chk("brk_hold", rx_active, 1'b1);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_flags", {parity_err, framing_err, break_int}, 3'b011);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_exit", rx_active, 1'b0);
    c0 = vld_cnt;
    send(8'h3C, 8, 0, 0, 0);
    expect_char("brk_3c", c0, 8'h3C, 0, 0, 0);

    // reset during bit 3 of 0xFF
    c0 = vld_cnt;
    fork
      send(8'hFF, 8, 0, 0, 0);
      begin
        repeat (64 * 4 + 32) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    join
    chk("ra_cnt", vld_cnt - c0, 0);
    chk("ra_data", rx_data, 8'h00);
    chk("ra_act", rx_active, 1'b0);
    chk("ra_flags", {rx_valid, parity_err, framing_err, break_int}, 4'h0);
    c0 = vld_cnt;
    send(8'h81, 8, 0, 0, 0);
    expect_char("ra_81", c0, 8'h81, 0, 0, 0);

    // rx_enable drop during bit 3 of 0xFF
    c0 = vld_cnt;
    fork
      send(8'hFF, 8, 0, 0, 0);
      begin
        repeat (64 * 4 + 32) @(negedge clk);
        rx_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("ea_act_lo", rx_active, 1'b0);
        rx_enable = 1'b1;
      end
    join
    chk("ea_cnt", vld_cnt - c0, 0);
    chk("ea_act", rx_active, 1'b0);
    c0 = vld_cnt;
    send(8'h81, 8, 0, 0, 0);
    expect_char("ea_81", c0, 8'h81, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
